// File: rtl/alu_share_pkg.sv
// Shared constants and helpers for the round-robin shared-ALU block.
// ALU opcodes, NZCV bit positions and the legal-opcode check.
package alu_share_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;
    localparam logic [2:0] ALU_EOR = 3'b100;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    function automatic logic ctrl_legal(input logic [2:0] ctrl);
        return (ctrl <= ALU_EOR);
    endfunction

endpackage

// File: rtl/alu32.sv
// 32-bit combinational ALU (ADD/SUB/AND/ORR/EOR) producing NZCV flags.
// Zero latency; no flow control.
module alu32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  ctrl,
    output logic [31:0] result,
    output logic [3:0]  flags
);
    import alu_share_pkg::*;

    logic [31:0] b_op;
    logic [32:0] sum;
    logic        c_flag;
    logic        v_flag;

    always_comb begin
        b_op   = ctrl[0] ? ~b : b;
        sum    = {1'b0, a} + {1'b0, b_op} + {32'd0, ctrl[0]};
        result = '0;
        c_flag = 1'b0;
        v_flag = 1'b0;
        case (ctrl)
            ALU_ADD, ALU_SUB: begin
                result = sum[31:0];
                c_flag = sum[32];
                v_flag = ~(a[31] ^ b[31] ^ ctrl[0]) & (a[31] ^ sum[31]);
            end
            ALU_AND: result = a & b;
            ALU_ORR: result = a | b;
            ALU_EOR: result = a ^ b;
            default: result = '0;
        endcase
        flags         = '0;
        flags[FLAG_N] = result[31];
        flags[FLAG_Z] = (result == 32'd0);
        flags[FLAG_C] = c_flag;
        flags[FLAG_V] = v_flag;
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first requesting index at or after ptr, wrapping.
// Combinational; grants at most one requester.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_idx,
    output logic                 grant_vld
);
    localparam int PW = $clog2(N);

    int idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        idx       = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!grant_vld && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = PW'(idx);
                grant_vld  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_share_arb.sv
// Shares one ALU among NREQ requesters via round-robin; result registered per requester (1 cycle).
// A requester is only granted when its response slot is empty or draining this cycle.
module alu_share_arb
    import alu_share_pkg::*;
#(
    parameter int         NREQ        = 2,
    parameter logic [3:0] FLAGS_RESET = 4'b0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*32-1:0] req_a,
    input  logic [NREQ*32-1:0] req_b,
    input  logic [NREQ*3-1:0] req_ctrl,
    input  logic [NREQ-1:0]   req_setflags,
    output logic [NREQ-1:0]   rsp_valid,
    input  logic [NREQ-1:0]   rsp_ready,
    output logic [NREQ*32-1:0] rsp_result,
    output logic [NREQ*4-1:0] rsp_flags,
    output logic [NREQ-1:0]   rsp_err,
    output logic [3:0]        flags_q
);
    localparam int PW = $clog2(NREQ);

    logic [PW-1:0]              ptr_q, ptr_d;
    logic [NREQ-1:0]            rsp_valid_q, rsp_valid_d;
    logic [NREQ-1:0]            rsp_err_q, rsp_err_d;
    logic [NREQ-1:0][31:0]      rsp_result_q, rsp_result_d;
    logic [NREQ-1:0][3:0]       rsp_flags_q, rsp_flags_d;
    logic [3:0]                 flags_d;

    logic [NREQ-1:0]            elig;
    logic [NREQ-1:0]            gnt;
    logic [PW-1:0]              gnt_idx;
    logic                       gnt_vld;

    logic [2:0]                 sel_ctrl;
    logic                       sel_legal;
    logic [31:0]                alu_a, alu_b, alu_result;
    logic [2:0]                 alu_ctrl;
    logic [3:0]                 alu_flags;

    // A full slot may be refilled in the same cycle it drains.
    assign elig = req_valid & (~rsp_valid_q | rsp_ready);

    rr_arbiter #(.N(NREQ)) u_arb (
        .req       (elig),
        .ptr       (ptr_q),
        .grant     (gnt),
        .grant_idx (gnt_idx),
        .grant_vld (gnt_vld)
    );

    assign req_ready = reset ? '0 : gnt;

    always_comb begin
        sel_ctrl  = ALU_ADD;
        sel_legal = 1'b0;
        alu_a     = '0;
        alu_b     = '0;
        alu_ctrl  = ALU_ADD;
        if (gnt_vld) begin
            sel_ctrl  = req_ctrl[3*gnt_idx +: 3];
            sel_legal = ctrl_legal(sel_ctrl);
            alu_a     = req_a[32*gnt_idx +: 32];
            alu_b     = req_b[32*gnt_idx +: 32];
            alu_ctrl  = sel_legal ? sel_ctrl : ALU_ADD;
        end
    end

    alu32 u_alu (
        .a      (alu_a),
        .b      (alu_b),
        .ctrl   (alu_ctrl),
        .result (alu_result),
        .flags  (alu_flags)
    );

    always_comb begin
        rsp_valid_d  = rsp_valid_q;
        rsp_err_d    = rsp_err_q;
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;
        flags_d      = flags_q;
        ptr_d        = ptr_q;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                rsp_valid_d[i]  = 1'b1;
                rsp_err_d[i]    = ~sel_legal;
                rsp_result_d[i] = sel_legal ? alu_result : 32'd0;
                rsp_flags_d[i]  = sel_legal ? alu_flags : 4'd0;
            end else if (rsp_ready[i]) begin
                rsp_valid_d[i]  = 1'b0;
                rsp_err_d[i]    = 1'b0;
                rsp_result_d[i] = '0;
                rsp_flags_d[i]  = '0;
            end
        end
        if (gnt_vld && sel_legal && req_setflags[gnt_idx]) begin
            flags_d = alu_flags;
        end
        if (gnt_vld) begin
            ptr_d = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q        <= '0;
            rsp_valid_q  <= '0;
            rsp_err_q    <= '0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
            flags_q      <= FLAGS_RESET;
        end else begin
            ptr_q        <= ptr_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_err_q    <= rsp_err_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
            flags_q      <= flags_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_err    = rsp_err_q;
    assign rsp_result = rsp_result_q;
    assign rsp_flags  = rsp_flags_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// Randomized bench for alu_share_arb against a queue-free behavioural model of arbitration,
// response slots and NZCV semantics, plus directed scenarios with literal expectations.
module tb_alu_share_arb;

    localparam int         N  = 2;
    localparam logic [3:0] FR = 4'b1010;

    logic            clk;
    logic            reset;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*32-1:0] req_a;
    logic [N*32-1:0] req_b;
    logic [N*3-1:0]  req_ctrl;
    logic [N-1:0]    req_setflags;
    logic [N-1:0]    rsp_valid;
    logic [N-1:0]    rsp_ready;
    logic [N*32-1:0] rsp_result;
    logic [N*4-1:0]  rsp_flags;
    logic [N-1:0]    rsp_err;
    logic [3:0]      flags_q;

    alu_share_arb #(.NREQ(N), .FLAGS_RESET(FR)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_ctrl     (req_ctrl),
        .req_setflags (req_setflags),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_flags    (rsp_flags),
        .rsp_err      (rsp_err),
        .flags_q      (flags_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Behavioural model state
    int          m_ptr;
    bit          m_v   [N];
    logic [31:0] m_res [N];
    logic [3:0]  m_fl  [N];
    bit          m_err [N];
    logic [3:0]  m_flags;
    logic [N-1:0] last_rdy;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // {err, N, Z, C, V, result} from the architectural definition of each op
    function automatic logic [36:0] ref_alu(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        bit cf, vf;
        cf = 0;
        vf = 0;
        case (c)
            3'd0: begin
                r  = a + b;
                cf = (64'(a) + 64'(b)) > 64'hFFFF_FFFF;
                vf = (a[31] == b[31]) && (r[31] != a[31]);
            end
            3'd1: begin
                r  = a - b;
                cf = (a >= b);
                vf = (a[31] != b[31]) && (r[31] != a[31]);
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            default: return {1'b1, 4'b0000, 32'd0};
        endcase
        return {1'b0, r[31], (r == 32'd0), cf, vf, r};
    endfunction

    function automatic int model_grant();
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (req_valid[i] && (!m_v[i] || rsp_ready[i])) return i;
        end
        return -1;
    endfunction

    task automatic model_step(input int g);
        logic [36:0] r;
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                m_v[i] = 0; m_res[i] = '0; m_fl[i] = '0; m_err[i] = 0;
            end
            m_flags = FR;
            m_ptr   = 0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (i == g) begin
                    r = ref_alu(req_ctrl[3*i +: 3], req_a[32*i +: 32], req_b[32*i +: 32]);
                    m_v[i]   = 1;
                    m_res[i] = r[31:0];
                    m_fl[i]  = r[35:32];
                    m_err[i] = r[36];
                    if (!r[36] && req_setflags[i]) m_flags = r[35:32];
                end else if (rsp_ready[i]) begin
                    m_v[i] = 0;
                end
            end
            if (g >= 0) m_ptr = (g + 1) % N;
        end
    endtask

    task automatic compare_all();
        logic [N-1:0] ev;
        for (int i = 0; i < N; i++) ev[i] = m_v[i];
        check("rsp_valid", 64'(rsp_valid), 64'(ev));
        for (int i = 0; i < N; i++) begin
            if (m_v[i]) begin
                check($sformatf("rsp_result%0d", i), 64'(rsp_result[32*i +: 32]), 64'(m_res[i]));
                check($sformatf("rsp_flags%0d", i), 64'(rsp_flags[4*i +: 4]), 64'(m_fl[i]));
                check($sformatf("rsp_err%0d", i), 64'(rsp_err[i]), 64'(m_err[i]));
            end
        end
        check("flags_q", 64'(flags_q), 64'(m_flags));
    endtask

    // One clock: inputs already driven after a falling edge.
    task automatic tick();
        int g;
        logic [N-1:0] er;
        #1;
        g  = model_grant();
        er = '0;
        if (!reset && g >= 0) er[g] = 1'b1;
        last_rdy = req_ready;
        check("req_ready", 64'(req_ready), 64'(er));
        @(posedge clk);
        model_step(g);
        #1;
        compare_all();
        @(negedge clk);
    endtask

    task automatic set_op(input int i, input logic [2:0] c, input logic [31:0] a,
                          input logic [31:0] b, input logic sf);
        req_ctrl[3*i +: 3] = c;
        req_a[32*i +: 32]  = a;
        req_b[32*i +: 32]  = b;
        req_setflags[i]    = sf;
    endtask

    function automatic logic [31:0] rnd_operand();
        logic [31:0] edge_vals [4];
        edge_vals[0] = 32'h0000_0000;
        edge_vals[1] = 32'hFFFF_FFFF;
        edge_vals[2] = 32'h8000_0000;
        edge_vals[3] = 32'h7FFF_FFFF;
        if ($urandom_range(0, 3) == 0) return edge_vals[$urandom_range(0, 3)];
        return $urandom();
    endfunction

    task automatic rnd_inputs();
        for (int i = 0; i < N; i++) begin
            set_op(i, 3'($urandom_range(0, 7)), rnd_operand(), rnd_operand(), 1'($urandom_range(0, 1)));
            req_valid[i] = ($urandom_range(0, 3) != 0);
            rsp_ready[i] = ($urandom_range(0, 2) != 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not finish within time limit");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; req_valid = '0; rsp_ready = '0;
        req_a = '0; req_b = '0; req_ctrl = '0; req_setflags = '0;
        tick();
        tick();
        check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset_flags", 64'(flags_q), 64'(FR));
        reset = 1'b0;

        // Both requesters continuously valid from ptr=0: grants alternate.
        req_valid = 2'b11; rsp_ready = 2'b11;
        set_op(0, 3'd0, 32'd1, 32'd2, 1'b0);
        set_op(1, 3'd2, 32'hF0, 32'h3C, 1'b0);
        tick(); check("alt_g0", 64'(last_rdy), 64'h1);
        tick(); check("alt_g1", 64'(last_rdy), 64'h2);
        tick(); check("alt_g2", 64'(last_rdy), 64'h1);
        tick(); check("alt_g3", 64'(last_rdy), 64'h2);
        check("alt_result1", 64'(rsp_result[63:32]), 64'h30);

        // Signed-overflow ADD with setflags.
        req_valid = 2'b01;
        set_op(0, 3'd0, 32'h7FFF_FFFF, 32'd1, 1'b1);
        tick();
        check("add_result", 64'(rsp_result[31:0]), 64'h8000_0000);
        check("add_flags", 64'(rsp_flags[3:0]), 64'h9);
        check("add_flags_q", 64'(flags_q), 64'h9);

        // SUB 5-5 on req1 held for 3 cycles.
        req_valid = 2'b10; rsp_ready = 2'b00;
        set_op(1, 3'd1, 32'd5, 32'd5, 1'b0);
        tick();
        check("sub_accept", 64'(last_rdy), 64'h2);
        set_op(1, 3'd3, 32'h1234, 32'h1, 1'b1);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("sub_hold_ready", 64'(last_rdy[1]), 64'h0);
            check("sub_hold_result", 64'(rsp_result[63:32]), 64'h0);
            check("sub_hold_flags", 64'(rsp_flags[7:4]), 64'h6);
            check("sub_hold_flags_q", 64'(flags_q), 64'h9);
        end
        req_valid = 2'b00; rsp_ready = 2'b10;
        tick();
        check("sub_drain", 64'(rsp_valid[1]), 64'h0);

        // Illegal opcode with setflags.
        req_valid = 2'b01; rsp_ready = 2'b01;
        set_op(0, 3'b111, 32'hDEAD_BEEF, 32'h1111_2222, 1'b1);
        tick();
        check("ill_err", 64'(rsp_err[0]), 64'h1);
        check("ill_result", 64'(rsp_result[31:0]), 64'h0);
        check("ill_flags_q", 64'(flags_q), 64'h9);
        req_valid = 2'b00; rsp_ready = 2'b00;
        tick();

        // Drain and re-accept in the same cycle.
        req_valid = 2'b01; rsp_ready = 2'b01;
        set_op(0, 3'd0, 32'd2, 32'd3, 1'b0);
        tick();
        check("b2b_accept", 64'(last_rdy), 64'h1);
        check("b2b_valid", 64'(rsp_valid[0]), 64'h1);
        check("b2b_result", 64'(rsp_result[31:0]), 64'h5);
        check("b2b_err", 64'(rsp_err[0]), 64'h0);

        // Random traffic with a 2-cycle reset in the middle.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rnd_inputs();
            if (cyc == 1500) begin
                reset = 1'b1;
                tick();
                rnd_inputs();
                tick();
                reset = 1'b0;
                check("mid_reset_valid", 64'(rsp_valid), 64'h0);
                check("mid_reset_flags", 64'(flags_q), 64'(FR));
                req_valid = 2'b11;
                tick();
                check("mid_reset_grant", 64'(last_rdy), 64'h1);
            end else begin
                tick();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
